// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline stage with valid/ready handshake and a 2-entry (main + skid) buffer.
// Optional stall-cycle counter is built when EX_MEM_STALL_CNT_EN is defined.
`timescale 1ns/1ps

// state   | meaning
// S_EMPTY | no entry held; outputs invalid
// S_ONE   | main holds the entry driving the outputs
// S_FULL  | main drives the outputs, skid holds the next entry; in_ready low
module ex_mem_pipe_stage #(
  parameter int XLEN   = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   adderout,
  input  logic [XLEN-1:0]   aluresult,
  input  logic              zero,
  input  logic [XLEN-1:0]   forwardbmuxout,
  input  logic [RD_W-1:0]   rd,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   adderout_reg,
  output logic [XLEN-1:0]   aluresult_reg,
  output logic              zero_out,
  output logic [XLEN-1:0]   forwardbmuxout_reg,
  output logic [RD_W-1:0]   rd_reg,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [31:0]       stall_cnt
);

  localparam int PW = 3 * XLEN + 1 + RD_W + CTRL_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   in_bus;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   skid_q;
  logic [CTRL_W-1:0] ctrl_main;
  logic            acc;
  logic            pop;

  assign in_bus = {adderout, aluresult, zero, forwardbmuxout, rd, ctrl_in};
  assign acc    = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Held payload is left stale; ctrl_out masking turns it into a bubble.
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (acc) begin
            main_q    <= in_bus;
            state     <= S_ONE;
            out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (acc && pop) begin
            main_q <= in_bus;
          end else if (acc) begin
            skid_q   <= in_bus;
            state    <= S_FULL;
            in_ready <= 1'b0;
          end else if (pop) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (pop) begin
            main_q   <= skid_q;
            state    <= S_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign {adderout_reg, aluresult_reg, zero_out, forwardbmuxout_reg, rd_reg, ctrl_main} = main_q;
  assign ctrl_out = out_valid ? ctrl_main : '0;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating; only reset clears it so flushes do not hide stall history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 32'h0;
    end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule
